// File: rtl/regfile_port_ctrl.sv
// Register file port controller: sequences operand reads and write-backs
// onto a single-clock 16x16 register file with registered read data.
// Write-back shares the port-1 select line and wins over a new read in IDLE;
// write-backs landing while operands are held are forwarded into them.
module regfile_port_ctrl #(
    parameter int DATA_W   = 16,
    parameter int SEL_W    = 4,
    parameter int FLAG_SEL = 14,
    parameter int PC_SEL   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_src1,
    input  logic [SEL_W-1:0]  req_src2,
    input  logic [SEL_W-1:0]  req_dst,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [SEL_W-1:0]  op_dst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [SEL_W-1:0]  wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    output logic [SEL_W-1:0]  rf_sel1,
    output logic [SEL_W-1:0]  rf_sel2,
    output logic [DATA_W-1:0] rf_in,
    output logic              rf_write_en,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2
);

    localparam logic [SEL_W-1:0] FLAG_IDX = SEL_W'(FLAG_SEL);
    localparam logic [SEL_W-1:0] PC_IDX   = SEL_W'(PC_SEL);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        HOLD
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] src1_q;
    logic [SEL_W-1:0] src2_q;
    logic             wb_accept;
    logic             wb_legal;
    logic             req_accept;
    logic             hit_a;
    logic             hit_b;

    // Handshake readiness: write-back is open in IDLE and HOLD, a new read only in IDLE with no write-back pending
    always_comb begin
        wb_ready  = 1'b0;
        req_ready = 1'b0;
        if (!rst) begin
            wb_ready  = (state == IDLE) || (state == HOLD);
            req_ready = (state == IDLE) && !wb_valid;
        end
    end

    assign wb_accept   = wb_valid && wb_ready;
    assign wb_legal    = (wb_sel != '0) && (wb_sel != FLAG_IDX) && (wb_sel != PC_IDX);
    assign req_accept  = req_valid && req_ready;

    // Write port: flags, PC and r0 are never strobed; illegal write-backs are swallowed
    assign rf_write_en = wb_accept && wb_legal;
    assign rf_sel1     = wb_accept ? wb_sel : src1_q;
    assign rf_sel2     = src2_q;
    assign rf_in       = wb_data;

    // Forwarding hits against the operands currently being held
    assign hit_a       = rf_write_en && (wb_sel == src1_q);
    assign hit_b       = rf_write_en && (wb_sel == src2_q);

    // Read sequencer: latch request, present selects, capture registered read data, hold until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            op_dst   <= '0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_accept) begin
                        src1_q <= req_src1;
                        src2_q <= req_src2;
                        op_dst <= req_dst;
                        state  <= READ;
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    op_a     <= rf_out1;
                    op_b     <= rf_out2;
                    op_valid <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        if (hit_a) begin
                            op_a <= wb_data;
                        end
                        if (hit_b) begin
                            op_b <= wb_data;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
